// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin arbiter in front of a 64x16 data memory
// Port A (CPU) and port B (loader/debug) share one registered-read memory; all outputs registered.
module data_mem_arbiter (
  input  logic        mem_clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [7:0]  a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [7:0]  b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [15:0] b_rdata,
  output logic        mem_dwe,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_last_b;
  logic r_win_b;
  logic r_we;

  logic        w_any_req;
  logic        w_a_wins;
  logic        w_we;
  logic [7:0]  w_addr;
  logic [15:0] w_wdata;
  logic        w_addr_ok;

  // On a tie the port that did not win last time is served.
  assign w_any_req = a_req | b_req;
  assign w_a_wins  = a_req & (~b_req | r_last_b);
  assign w_we      = w_a_wins ? a_we    : b_we;
  assign w_addr    = w_a_wins ? a_addr  : b_addr;
  assign w_wdata   = w_a_wins ? a_wdata : b_wdata;
  assign w_addr_ok = (w_addr[7:6] == 2'b00);

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = w_addr_ok ? ISSUE : ACK;
        end
      end
      ISSUE:   w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      r_last_b  <= 1'b1;
      r_win_b   <= 1'b0;
      r_we      <= 1'b0;
      a_ack     <= 1'b0;
      a_err     <= 1'b0;
      a_rdata   <= 16'h0000;
      b_ack     <= 1'b0;
      b_err     <= 1'b0;
      b_rdata   <= 16'h0000;
      mem_dwe   <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      busy <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_win_b  <= ~w_a_wins;
            r_last_b <= ~w_a_wins;
            r_we     <= w_we;
            if (w_addr_ok) begin
              mem_addr  <= w_addr;
              mem_wdata <= w_wdata;
              mem_dwe   <= w_we;
            end else if (w_a_wins) begin
              a_ack   <= 1'b1;
              a_err   <= 1'b1;
              a_rdata <= 16'h0000;
            end else begin
              b_ack   <= 1'b1;
              b_err   <= 1'b1;
              b_rdata <= 16'h0000;
            end
          end
        end
        ISSUE: begin
          mem_dwe <= 1'b0;
        end
        CAPTURE: begin
          // mem_rdata now reflects the address presented during ISSUE.
          if (r_win_b) begin
            b_ack <= 1'b1;
            b_err <= 1'b0;
            if (!r_we) b_rdata <= mem_rdata;
          end else begin
            a_ack <= 1'b1;
            a_err <= 1'b0;
            if (!r_we) a_rdata <= mem_rdata;
          end
        end
        ACK: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          a_err <= 1'b0;
          b_err <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized scoreboard bench for data_mem_arbiter
// Reference model predicts grant order, ack cycle, err/rdata, memory write pulses and busy.
module tb_data_mem_arbiter;

  logic        mem_clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [7:0]  a_addr = 8'h00;
  logic [15:0] a_wdata = 16'h0000;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [7:0]  b_addr = 8'h00;
  logic [15:0] b_wdata = 16'h0000;
  logic        a_ack, a_err, b_ack, b_err, mem_dwe, busy;
  logic [15:0] a_rdata, b_rdata, mem_wdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = 16'h0000;

  data_mem_arbiter dut (
    .mem_clk(mem_clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_dwe(mem_dwe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {logic we; logic [7:0] addr; logic [15:0] wdata; int gap;} op_t;
  typedef struct {int port; int cyc; logic err; logic [15:0] rdata;} exp_t;
  typedef struct {int cyc; logic [7:0] addr; logic [15:0] wdata;} dwe_t;

  op_t  opq_a[$];
  op_t  opq_b[$];
  exp_t exp_q[$];
  dwe_t dwe_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [15:0] tb_mem [64];
  logic [15:0] ref_mem [64];

  // Reference model state
  int          next_edge = 0;
  logic        last_b = 1'b1;
  int          busy_from = -1;
  int          busy_to = -2;
  logic [15:0] mrd_a = 16'h0000, mrd_b = 16'h0000;
  logic [15:0] seen_a = 16'h0000, seen_b = 16'h0000;

  initial begin
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = 16'($urandom);
      ref_mem[i] = tb_mem[i];
    end
  end

  always @(posedge mem_clk) cyc <= cyc + 1;

  // Registered-read data memory
  always @(posedge mem_clk) begin
    if (mem_dwe) tb_mem[mem_addr[5:0]] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr[5:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge mem_clk or negedge reset) begin
    int p;
    logic wa, wb, we, err;
    logic [7:0] addr;
    logic [15:0] wd, rd;
    if (!reset) begin
      exp_q.delete();
      dwe_q.delete();
      next_edge = 0;
      last_b = 1'b1;
      busy_from = -1;
      busy_to = -2;
      mrd_a = 16'h0000; mrd_b = 16'h0000;
      seen_a = 16'h0000; seen_b = 16'h0000;
    end else begin
      p = cyc + 1;
      if (p >= next_edge && (a_req || b_req)) begin
        wa = a_req && (!b_req || last_b);
        wb = !wa;
        last_b = wb;
        we   = wb ? b_we : a_we;
        addr = wb ? b_addr : a_addr;
        wd   = wb ? b_wdata : a_wdata;
        err  = (addr >= 8'd64);
        if (err) rd = 16'h0000;
        else if (!we) rd = ref_mem[addr[5:0]];
        else begin
          rd = wb ? mrd_b : mrd_a;
          ref_mem[addr[5:0]] = wd;
          dwe_q.push_back('{p, addr, wd});
        end
        if (wb) mrd_b = rd; else mrd_a = rd;
        exp_q.push_back('{int'(wb), err ? p : p + 2, err, rd});
        busy_from = p;
        busy_to   = err ? p : p + 2;
        next_edge = err ? p + 2 : p + 4;
      end
    end
  end

  task automatic take_ack(input int port, input logic err, input logic [15:0] rd);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_ack: got ack on port %0d at cycle %0d, required none", port, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("ack_port", port, e.port);
      chk("ack_cycle", cyc, e.cyc);
      chk("ack_err", err, e.err);
      chk("ack_rdata", rd, e.rdata);
      if (port == 0) seen_a = e.rdata; else seen_b = e.rdata;
    end
  endtask

  always @(negedge mem_clk) begin
    dwe_t d;
    if (reset) begin
      if (a_ack) take_ack(0, a_err, a_rdata); else chk("a_rdata_hold", a_rdata, seen_a);
      if (b_ack) take_ack(1, b_err, b_rdata); else chk("b_rdata_hold", b_rdata, seen_b);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missing_ack: port %0d got none, required ack at cycle %0d", exp_q[0].port, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (mem_dwe) begin
        if (dwe_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_dwe: got mem_dwe=1 addr %0h at cycle %0d, required 0", mem_addr, cyc);
        end else begin
          d = dwe_q.pop_front();
          chk("dwe_cycle", cyc, d.cyc);
          chk("dwe_addr", mem_addr, d.addr);
          chk("dwe_wdata", mem_wdata, d.wdata);
        end
      end
      while (dwe_q.size() > 0 && dwe_q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missing_dwe: got none, required write addr %0h at cycle %0d", dwe_q[0].addr, dwe_q[0].cyc);
        void'(dwe_q.pop_front());
      end
      chk("busy", busy, (cyc >= busy_from && cyc <= busy_to));
    end
  end

  task automatic set_port(input int port, input logic req, input op_t op);
    if (port == 0) begin
      a_req = req; a_we = op.we; a_addr = op.addr; a_wdata = op.wdata;
    end else begin
      b_req = req; b_we = op.we; b_addr = op.addr; b_wdata = op.wdata;
    end
  endtask

  task automatic add_op(input int port, input logic we, input logic [7:0] addr, input logic [15:0] wd, input int gap);
    op_t op;
    op = '{we, addr, wd, gap};
    if (port == 0) opq_a.push_back(op); else opq_b.push_back(op);
  endtask

  task automatic run_port(input int port);
    op_t op;
    int t;
    logic ack;
    while ((port == 0 ? opq_a.size() : opq_b.size()) > 0) begin
      if (port == 0) op = opq_a.pop_front(); else op = opq_b.pop_front();
      if (op.gap > 0) begin
        set_port(port, 1'b0, op);
        repeat (op.gap) @(negedge mem_clk);
      end
      set_port(port, 1'b1, op);
      t = 0;
      ack = 1'b0;
      while (!ack && t < 40) begin
        @(negedge mem_clk);
        t++;
        ack = (port == 0) ? a_ack : b_ack;
      end
      if (!ack) begin
        total++; bad++;
        $display("FAIL driver_timeout: port %0d got no ack within 40 cycles, required ack", port);
      end
    end
    op = '{1'b0, 8'h00, 16'h0000, 0};
    set_port(port, 1'b0, op);
  endtask

  task automatic run_both();
    fork
      run_port(0);
      run_port(1);
    join
    repeat (6) @(negedge mem_clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(negedge mem_clk);
    reset = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values before any clock edge
    #2;
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_err", b_err, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_mem_dwe", mem_dwe, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    @(negedge mem_clk);
    @(negedge mem_clk);
    reset = 1'b1;
    @(negedge mem_clk);

    // A write 5 <- 0x1234, then B read 5
    add_op(0, 1'b1, 8'd5, 16'h1234, 0);
    run_both();
    add_op(1, 1'b0, 8'd5, 16'h0000, 0);
    run_both();
    chk("b_read_after_a_write", b_rdata, 16'h1234);

    // Simultaneous requests right after reset: A first
    pulse_reset();
    add_op(0, 1'b0, 8'd7, 16'h0000, 0);
    add_op(1, 1'b0, 8'd9, 16'h0000, 0);
    run_both();

    // Continuous contention: strict alternation
    for (int i = 0; i < 4; i++) begin
      add_op(0, 1'b0, 8'd1, 16'h0000, 0);
      add_op(1, 1'b0, 8'd2, 16'h0000, 0);
    end
    run_both();

    // Address error
    add_op(0, 1'b0, 8'h40, 16'h0000, 0);
    run_both();
    chk("a_err_rdata_zero", a_rdata, 16'h0000);

    // Reset during CAPTURE of an A read
    a_we = 1'b0; a_addr = 8'd3; a_req = 1'b1;
    @(negedge mem_clk);
    @(negedge mem_clk);
    reset = 1'b0;
    a_req = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_mem_dwe", mem_dwe, 0);
    chk("abort_a_ack", a_ack, 0);
    repeat (3) @(negedge mem_clk);
    chk("abort_no_ack", a_ack, 0);
    reset = 1'b1;
    @(negedge mem_clk);
    add_op(1, 1'b0, 8'd5, 16'h0000, 0);
    run_both();
    chk("b_read_after_abort", b_rdata, 16'h1234);

    // B back-to-back writes then readback
    add_op(1, 1'b1, 8'd0, 16'hA0A0, 0);
    add_op(1, 1'b1, 8'd1, 16'hB1B1, 0);
    add_op(1, 1'b1, 8'd2, 16'hC2C2, 0);
    add_op(1, 1'b0, 8'd0, 16'h0000, 0);
    add_op(1, 1'b0, 8'd1, 16'h0000, 0);
    add_op(1, 1'b0, 8'd2, 16'h0000, 0);
    run_both();
    chk("b_readback_last", b_rdata, 16'hC2C2);

    // Randomized traffic on both ports
    for (int i = 0; i < 30; i++) begin
      for (int port = 0; port < 2; port++) begin
        add_op(port, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 15)),
               16'($urandom), int'($urandom_range(0, 2)));
      end
    end
    run_both();

    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_dwe_empty", dwe_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
